toggle_event_gen: RTL and testbench

TOGGLE_EVENT_GEN -- requirements
Module: toggle_event_gen

---
 rtl/toggle_event_gen.sv | 129 ++++++++++++
 tb/tb_toggle_event_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_gen.sv
// Per-bit rise/fall toggle detector with sticky coverage map and a first-hit event port.
// Pulses lag the sample by one cycle; an offered event holds until evt_ready, one event per two cycles.
module toggle_event_gen #(
  parameter int WIDTH       = 8,
  parameter int COVER_BASE  = 0,
  parameter int COVER_TOTAL = 8940
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           en,
  input  logic [WIDTH-1:0]               sig,
  output logic [WIDTH-1:0]               rise_valid,
  output logic [WIDTH-1:0]               fall_valid,
  output logic [2*WIDTH-1:0]             covered,
  output logic [$clog2(2*WIDTH+1)-1:0]   covered_cnt,
  output logic                           all_covered,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [63:0]                    evt_index
);

  localparam int NPT = 2 * WIDTH;
  localparam int CW  = $clog2(NPT + 1);
  localparam int IW  = (NPT > 1) ? $clog2(NPT) : 1;
  localparam logic [63:0] BASE64 = 64'(COVER_BASE);

  if (COVER_BASE + 2 * WIDTH > COVER_TOTAL) begin : g_cfg_err
    $error("toggle_event_gen: cover range exceeds COVER_TOTAL");
  end

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic            primed;
  logic [NPT-1:0]  hits;
  logic [NPT-1:0]  pending;
  logic [NPT-1:0]  clr_mask;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   low_idx;
  logic [CW-1:0]   cnt_nxt;
  logic            latch;
  logic            accept;

  // Interleave pulses into cover-point order: rise at 2i, fall at 2i+1.
  always_comb begin
    hits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hits[2*i]   = rise_valid[i];
      hits[2*i+1] = fall_valid[i];
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = NPT - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = IW'(i);
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NPT; i++) begin
      cnt_nxt = cnt_nxt + CW'(covered[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    evt_valid = 1'b0;
    latch     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_nxt = OFFER;
          latch     = 1'b1;
        end
      end
      OFFER: begin
        evt_valid = 1'b1;
        if (evt_ready) begin
          state_nxt = IDLE;
          accept    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[sel] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      prev        <= '0;
      primed      <= 1'b0;
      rise_valid  <= '0;
      fall_valid  <= '0;
      covered     <= '0;
      covered_cnt <= '0;
      all_covered <= 1'b0;
      pending     <= '0;
      sel         <= '0;
      evt_index   <= '0;
    end else begin
      state <= state_nxt;
      if (en) begin
        prev   <= sig;
        primed <= 1'b1;
      end
      rise_valid  <= (en && primed) ? (~prev & sig) : '0;
      fall_valid  <= (en && primed) ? (prev & ~sig) : '0;
      covered     <= covered | hits;
      covered_cnt <= cnt_nxt;
      all_covered <= (cnt_nxt == CW'(NPT));
      // The offered bit is already covered, so it cannot be re-set in the cycle it clears.
      pending     <= (pending & ~clr_mask) | (hits & ~covered);
      if (latch) begin
        sel       <= low_idx;
        evt_index <= BASE64 + 64'(low_idx);
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_gen.sv
// Directed and randomized checks of toggle_event_gen against a set-based reference model.
module tb_toggle_event_gen;

  localparam int W    = 4;
  localparam int BASE = 100;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] sig = '0;
  logic         evt_ready = 1'b0;
  logic [W-1:0] rise_valid, fall_valid;
  logic [2*W-1:0] covered;
  logic [3:0]   covered_cnt;
  logic         all_covered, evt_valid;
  logic [63:0]  evt_index;

  toggle_event_gen #(.WIDTH(W), .COVER_BASE(BASE), .COVER_TOTAL(8940)) dut (
    .clock(clock), .reset(reset), .en(en), .sig(sig),
    .rise_valid(rise_valid), .fall_valid(fall_valid),
    .covered(covered), .covered_cnt(covered_cnt), .all_covered(all_covered),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Reference model: sets of seen / pending cover points plus the current offer.
  logic [W-1:0]   m_prev, m_rise, m_fall;
  logic           m_primed;
  logic [2*W-1:0] m_cov, m_pend;
  int             m_cnt;
  logic           m_all, m_offer;
  int             m_p;
  int             acc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_prev = '0; m_rise = '0; m_fall = '0; m_primed = 1'b0;
    m_cov = '0; m_pend = '0; m_cnt = 0; m_all = 1'b0; m_offer = 1'b0; m_p = 0;
  endtask

  task automatic model_update(input logic r, input logic e, input logic [W-1:0] s, input logic rdy);
    logic [2*W-1:0] hits;
    int lo;
    if (r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < W; i++) begin
      hits[2*i]   = m_rise[i];
      hits[2*i+1] = m_fall[i];
    end
    m_cnt = $countones(m_cov);
    m_all = (m_cnt == 2 * W);
    if (m_offer) begin
      if (rdy) begin
        m_pend[m_p] = 1'b0;
        m_offer = 1'b0;
      end
    end else if (m_pend != 0) begin
      lo = 0;
      for (int k = 2 * W - 1; k >= 0; k--) if (m_pend[k]) lo = k;
      m_p = lo;
      m_offer = 1'b1;
    end
    m_pend = m_pend | (hits & ~m_cov);
    m_cov  = m_cov | hits;
    if (e && m_primed) begin
      m_rise = ~m_prev & s;
      m_fall = m_prev & ~s;
    end else begin
      m_rise = '0;
      m_fall = '0;
    end
    if (e) begin
      m_prev = s;
      m_primed = 1'b1;
    end
  endtask

  task automatic check_all();
    check("rise_valid", 64'(rise_valid), 64'(m_rise));
    check("fall_valid", 64'(fall_valid), 64'(m_fall));
    check("covered", 64'(covered), 64'(m_cov));
    check("covered_cnt", 64'(covered_cnt), 64'(m_cnt));
    check("all_covered", 64'(all_covered), 64'(m_all));
    check("evt_valid", 64'(evt_valid), 64'(m_offer));
    if (m_offer) check("evt_index", evt_index, 64'(BASE + m_p));
  endtask

  task automatic cyc(input logic r, input logic e, input logic [W-1:0] s, input logic rdy);
    reset = r; en = e; sig = s; evt_ready = rdy;
    if (!r && rdy && evt_valid) acc.push_back(int'(evt_index));
    @(posedge clock);
    model_update(r, e, s, rdy);
    @(negedge clock);
    check_all();
  endtask

  initial begin
    int exp_seq[8] = '{100, 102, 104, 106, 101, 103, 105, 107};
    logic [W-1:0] s, flip;
    logic r, e, rdy;
    model_reset();

    // Reset state
    cyc(1, 0, 4'b0000, 0);
    cyc(1, 0, 4'b0000, 0);
    check("reset_evt_index", evt_index, 64'd0);
    check("reset_evt_valid", 64'(evt_valid), 64'd0);
    check("reset_covered", 64'(covered), 64'd0);

    // First enabled sample only primes; the next rise pulses one cycle later
    cyc(0, 1, 4'b0000, 0);
    check("prime_no_pulse", 64'(rise_valid | fall_valid), 64'd0);
    cyc(0, 1, 4'b0001, 0);
    check("first_rise", 64'(rise_valid), 64'h1);
    cyc(0, 1, 4'b0001, 0);
    check("first_covered", 64'(covered), 64'h01);

    // Full sweep with consumer always ready: rises drain before falls arrive
    cyc(1, 0, 4'b0000, 1);
    acc.delete();
    cyc(0, 1, 4'b0000, 1);
    repeat (16) cyc(0, 1, 4'b1111, 1);
    repeat (20) cyc(0, 1, 4'b0000, 1);
    check("sweep_count", 64'(acc.size()), 64'd8);
    for (int i = 0; i < 8 && i < acc.size(); i++) check("sweep_index", 64'(acc[i]), 64'(exp_seq[i]));
    check("sweep_cnt", 64'(covered_cnt), 64'd8);
    check("sweep_all", 64'(all_covered), 64'd1);

    // Disabled sampling ignores toggles; re-enable with the last enabled value
    for (int i = 0; i < 6; i++) cyc(0, 0, 4'(i * 5 + 3), 1);
    cyc(0, 1, 4'b0000, 1);
    cyc(0, 1, 4'b0000, 1);
    check("reenable_no_pulse", 64'(rise_valid | fall_valid), 64'd0);

    // Covered bits still pulse but raise no event
    cyc(0, 1, 4'b0001, 1);
    check("repeat_rise", 64'(rise_valid), 64'h1);
    cyc(0, 1, 4'b0000, 1);
    check("repeat_fall", 64'(fall_valid), 64'h1);
    repeat (3) cyc(0, 1, 4'b0000, 1);
    check("repeat_no_evt", 64'(evt_valid), 64'd0);
    check("repeat_cnt", 64'(covered_cnt), 64'd8);

    // Stalled offer keeps its index while a lower point becomes pending
    cyc(1, 0, 4'b0000, 0);
    cyc(0, 1, 4'b0000, 0);
    for (int i = 0; i < 8 && !evt_valid; i++) cyc(0, 1, 4'b1000, 0);
    check("stall_offer", 64'(evt_valid), 64'd1);
    check("stall_first_idx", evt_index, 64'(BASE + 6));
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 4'b1001, 0);
      check("stall_hold_idx", evt_index, 64'(BASE + 6));
    end
    cyc(0, 1, 4'b1001, 1);
    cyc(0, 1, 4'b1001, 0);
    check("stall_next_valid", 64'(evt_valid), 64'd1);
    check("stall_next_idx", evt_index, 64'(BASE + 0));

    // Reset mid-offer drops the event; the point re-fires afterwards
    cyc(1, 1, 4'b1001, 1);
    check("rst_offer_valid", 64'(evt_valid), 64'd0);
    check("rst_offer_cov", 64'(covered), 64'd0);
    check("rst_offer_cnt", 64'(covered_cnt), 64'd0);
    cyc(0, 1, 4'b0000, 0);
    repeat (4) cyc(0, 1, 4'b0001, 0);
    check("refire_valid", 64'(evt_valid), 64'd1);
    check("refire_idx", evt_index, 64'(BASE + 0));

    // Randomized traffic against the model
    s = '0;
    for (int n = 0; n < 2000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 1) == 1);
      flip = 4'($urandom);
      if ($urandom_range(0, 2) != 0) flip = '0;
      s = s ^ flip;
      cyc(r, e, s, rdy);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
